// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO controller and its CSR-facing status export.
package fifo_pkg;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int FIFO_AWIDTH_DEF = 4;
    localparam int FIFO_DEPTH_DEF  = depth_of(FIFO_AWIDTH_DEF);

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic err_ovf;
        logic err_udf;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller that sequences an external RAM with synchronous write and combinational read.
// It owns the pointers, the occupancy count, the threshold flags and the sticky error flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DWIDTH   = 25,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [AWIDTH-1:0] mem_raddr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH:0]   count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam logic [AWIDTH:0] AF_L = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_L = (AWIDTH+1)'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > depth_of(AWIDTH)) begin : g_bad_af
        $error("fifo_ctrl: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > depth_of(AWIDTH) - 1) begin : g_bad_ae
        $error("fifo_ctrl: AE_LEVEL out of range");
    end

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AWIDTH:0] wptr, rptr, count_q, count_nxt;
    logic            af_q, ae_q, ovf_q, udf_q;
    logic            push, pop;
    fifo_status_t    st;

    assign st.full         = (wptr[AWIDTH] != rptr[AWIDTH]) &&
                             (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
    assign st.empty        = (wptr == rptr);
    assign st.almost_full  = af_q;
    assign st.almost_empty = ae_q;
    assign st.err_ovf      = ovf_q;
    assign st.err_udf      = udf_q;

    assign in_ready     = !st.full;
    assign out_valid    = !st.empty;
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;

    assign mem_wen      = push & !flush;
    assign mem_waddr    = wptr[AWIDTH-1:0];
    assign mem_raddr    = rptr[AWIDTH-1:0];
    assign mem_wdata    = in_data;
    assign out_data     = mem_rdata;

    assign count        = count_q;
    assign almost_full  = st.almost_full;
    assign almost_empty = st.almost_empty;
    assign err_ovf      = st.err_ovf;
    assign err_udf      = st.err_udf;

    always_comb begin
        count_nxt = count_q;
        if (push && !pop)
            count_nxt = count_q + 1'b1;
        else if (pop && !push)
            count_nxt = count_q - 1'b1;
    end

    // Threshold flags come from the next count so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count_q <= count_nxt;
            af_q    <= (count_nxt >= AF_L);
            ae_q    <= (count_nxt <= AE_L);
            ovf_q   <= ovf_q | (in_valid & st.full);
            udf_q   <= udf_q | (out_ready & st.empty);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized scoreboard bench for fifo_ctrl with a behavioural RAM and a queue-based reference model.
module tb_fifo_ctrl;
    localparam int DW = 25;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 12;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW:0]   count;
    logic          almost_full, almost_empty, err_ovf, err_udf;

    fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write, combinational read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_wen) ram[mem_waddr] <= mem_wdata;
    assign mem_rdata = ram[mem_raddr];

    typedef struct {
        bit iready, ovalid, af, ae, ovf, udf, wen;
        int cnt;
    } exp_t;

    exp_t          stat_q[$];
    logic [DW-1:0] data_q[$];
    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 0;

    // Reference model state: occupancy and sticky errors.
    int m_n = 0;
    bit m_ovf = 0, m_udf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        e.iready = (m_n < DEPTH);
        e.ovalid = (m_n > 0);
        e.cnt    = m_n;
        e.af     = (m_n >= AF);
        e.ae     = (m_n <= AE);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.wen    = iv && (m_n < DEPTH) && !fl;
        mon_en = 1;
        stat_q.push_back(e);
        if (fl) begin
            m_n = 0; m_ovf = 0; m_udf = 0;
        end else begin
            bit pu, po;
            pu = iv && (m_n < DEPTH);
            po = ordy && (m_n > 0);
            if (iv && m_n == DEPTH) m_ovf = 1;
            if (ordy && m_n == 0) m_udf = 1;
            m_n = m_n + int'(pu) - int'(po);
            if (pu) data_q.push_back(d);
        end
    endtask

    // Monitor: status compared every cycle, data popped whenever the DUT hands a word over.
    always @(negedge clk) begin
        if (mon_en && rst_n && stat_q.size() > 0) begin
            exp_t e;
            e = stat_q.pop_front();
            chk("in_ready", int'(in_ready), int'(e.iready));
            chk("out_valid", int'(out_valid), int'(e.ovalid));
            chk("count", int'(count), e.cnt);
            chk("almost_full", int'(almost_full), int'(e.af));
            chk("almost_empty", int'(almost_empty), int'(e.ae));
            chk("err_ovf", int'(err_ovf), int'(e.ovf));
            chk("err_udf", int'(err_udf), int'(e.udf));
            chk("mem_wen", int'(mem_wen), int'(e.wen));
            if (flush) begin
                data_q.delete();
            end else if (out_valid && out_ready) begin
                if (data_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_data act=%0h exp=none (scoreboard empty)", out_data);
                end else begin
                    chk("out_data", int'(out_data), int'(data_q.pop_front()));
                end
            end
        end
    end

    task automatic idle_check(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_almost_empty"}, int'(almost_empty), 1);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_err"}, int'({err_ovf, err_udf}), 0);
        chk({tag, "_mem_wen"}, int'(mem_wen), 0);
    endtask

    initial begin
        #23 rst_n = 1'b1;
        #1 idle_check("reset");

        // Fill with 1..16 and hold, then drain in order.
        for (int i = 1; i <= 16; i++) drive(1, DW'(i), 0, 0);
        drive(1, DW'(99), 0, 0);
        for (int i = 0; i < 16; i++) drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);

        // Wrap-around: pointers cross the top of the RAM twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) drive(1, DW'($urandom), 0, 0);
            for (int i = 0; i < 10; i++) drive(0, '0, 1, 0);
        end

        // Concurrent push/pop at count 5.
        for (int i = 0; i < 5; i++) drive(1, DW'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) drive(1, DW'($urandom), 1, 0);
        drive(0, '0, 0, 1);

        // Full with both handshakes: pop only, overflow flagged.
        for (int i = 0; i < 16; i++) drive(1, DW'($urandom), 0, 0);
        drive(1, DW'($urandom), 1, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 1);

        // Underflow sticks through traffic until flush.
        drive(0, '0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, DW'($urandom), 1, 0);
        drive(0, '0, 0, 1);
        drive(0, '0, 0, 0);

        // Flush at count 7 while pushing.
        for (int i = 0; i < 7; i++) drive(1, DW'($urandom), 0, 0);
        drive(1, DW'($urandom), 1, 1);
        drive(0, '0, 1, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 3000; i++)
            drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0 || (i / 500) % 2 == 1,
                  ($urandom % 97) == 0);

        // Async reset mid-burst, checked before any clock edge.
        for (int i = 0; i < 9; i++) drive(1, DW'($urandom), 0, 0);
        drive(1, DW'($urandom), 0, 0);
        #2;
        mon_en = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1 idle_check("async_rst");
        stat_q.delete(); data_q.delete();
        m_n = 0; m_ovf = 0; m_udf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1, DW'($urandom), ($urandom % 2) == 0, 0);
        for (int i = 0; i < 20; i++) drive(0, '0, 1, 0);
        @(posedge clk);
        #1 mon_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous single-clock FIFO controller that sequences one instance of the team's dual-port RAM (`fifomem`, DWIDTH x 2^AWIDTH, synchronous write, combinational read).
- Owns write and read pointers, occupancy count, full/empty/threshold flags, flush and error reporting.
- Presents valid/ready streams on both sides.
- Sits between a producer stage and a consumer stage wherever the datapath needs elastic buffering.

Parameters:
- DWIDTH, 25, data word width; must match the RAM.
- AWIDTH, 4, RAM address width; depth DEPTH = 2^AWIDTH (16).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of contents; pulse.
- in_valid, input, 1, producer has data.
- in_ready, output, 1, controller accepts data (= !full).
- in_data, input, DWIDTH, write data.
- out_valid, output, 1, data available (= !empty).
- out_ready, input, 1, consumer takes data.
- out_data, output, DWIDTH, head-of-FIFO word; equals mem_rdata.
- mem_wen, output, 1, RAM write enable.
- mem_waddr, output, AWIDTH, RAM write address.
- mem_raddr, output, AWIDTH, RAM read address.
- mem_wdata, output, DWIDTH, RAM write data (= in_data).
- mem_rdata, input, DWIDTH, RAM read data.
- count, output, AWIDTH+1, current occupancy 0..DEPTH.
- almost_full, output, 1, registered; count >= AF_LEVEL.
- almost_empty, output, 1, registered; count <= AE_LEVEL.
- err_ovf, output, 1, sticky: in_valid while full.
- err_udf, output, 1, sticky: out_ready while empty.

Behaviour:
- **Reset (rst_n low, async):**
  - wptr = rptr = 0; count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - err_ovf = err_udf = 0.
  - Consequently in_ready = 1, out_valid = 0, mem_wen = 0.
- **Pointers:**
  - wptr and rptr are AWIDTH+1 bits; the MSB is the wrap bit.
  - mem_waddr = wptr[AWIDTH-1:0]; mem_raddr = rptr[AWIDTH-1:0].
  - full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
  - Wrap from DEPTH-1 to 0 is natural modulo-2^(AWIDTH+1) increment.
- **Handshakes:**
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - mem_wen = push, combinational.
  - push increments wptr; pop increments rptr.
  - count += push - pop, so simultaneous push and pop leaves count unchanged.
- **Latency:**
  - A word pushed on edge N is visible on out_data with out_valid = 1 after edge N; no bypass when empty.
  - out_data is combinational from mem_rdata and only meaningful when out_valid = 1.
- **Full:**
  - in_ready = 0; no write occurs even if out_ready pops in the same cycle (no pass-through).
  - in_ready returns 1 in the cycle after the pop.
- **Empty:** out_valid = 0; pop is impossible.
- **Flags:** almost_full and almost_empty are computed from next-count and registered, so they are valid in the same cycle as count.
- **Errors:**
  - err_ovf sets when in_valid & full; err_udf sets when out_ready & empty.
  - Both stay set until rst_n or flush.
  - Neither affects data or pointers.
- **Flush:**
  - Takes priority over push and pop in the same cycle.
  - Next state: pointers 0, count 0, flags as reset, errors cleared.
  - mem_wen is forced 0 during the flush cycle.
  - RAM contents are not cleared.
- **Reset mid-operation:** immediate return to reset state, regardless of handshake in flight.
- No state machine beyond the pointer/count registers; all state updates on the rising edge of clk.

Decomposition:
- Shared package `fifo_pkg`:
  - Localparam helper for DEPTH.
  - Typedef `fifo_status_t` struct {full, empty, almost_full, almost_empty, err_ovf, err_udf}, for status export to CSRs.
- Sub-module: none required.
- Optional wrapper `sync_fifo` instantiates `fifo_ctrl` plus `fifomem`, wiring `mem_*` to the RAM ports (wen, waddr, raddr, wdata, rdata).

Test Plan:
- **Reset/idle:** release rst_n with no traffic -> count = 0, in_ready = 1, out_valid = 0, almost_empty = 1, mem_wen = 0.
- **Fill/drain:**
  - Push 0x000001..0x000010 (16 words), out_ready = 0 -> full after the 16th edge, in_ready = 0, count = 16; almost_full rises when count reaches 12.
  - Then drain -> out_data sequence 0x000001..0x000010 in order, out_valid drops after the last pop.
- **Wrap-around:** push 10 and pop 10 twice (pointers cross index 15 -> 0) -> data order preserved, count never exceeds 10, wptr MSB toggles.
- **Simultaneous push/pop:**
  - At count = 5 -> count stays 5 and the head advances.
  - At full with in_valid = 1 and out_ready = 1 -> pop only, count = 15, err_ovf = 1.
- **Error flags:** out_ready = 1 while empty -> err_udf = 1 and stays set across further traffic; a flush pulse clears it.
- **Flush/reset mid-stream:**
  - Flush at count = 7 with push asserted -> count = 0, out_valid = 0, mem_wen = 0 that cycle.
  - Async rst_n low mid-burst -> outputs at reset values without waiting for a clock edge.
